// File: rtl/nasti_request_queue.sv
// NASTI read/write address request queue feeding the DDR3 command generator.
// Optional same-cycle bypass of an empty queue: define NASTI_REQUEST_QUEUE_BYPASS_EN.
module nasti_request_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ID_W  = 4
) (
  input  logic            core_clk,
  input  logic            core_rst,
  input  logic            ar_valid,
  output logic            ar_ready,
  input  logic [31:0]     ar_addr,
  input  logic [ID_W-1:0] ar_id,
  input  logic [7:0]      ar_len,
  input  logic            aw_valid,
  output logic            aw_ready,
  input  logic [31:0]     aw_addr,
  input  logic [ID_W-1:0] aw_id,
  input  logic [7:0]      aw_len,
  output logic            rq_valid,
  input  logic            rq_ready,
  output logic            rq_write,
  output logic [2:0]      rq_bank,
  output logic [13:0]     rq_row,
  output logic [9:0]      rq_col,
  output logic [ID_W-1:0] rq_id,
  output logic [7:0]      rq_len,
  output logic            r_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {GRANT_READ, GRANT_WRITE} grant_t;

  typedef struct packed {
    logic            write;
    logic [2:0]      bank;
    logic [13:0]     row;
    logic [9:0]      col;
    logic [ID_W-1:0] id;
    logic [7:0]      len;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [CW-1:0]   rd_ptr, wr_ptr, count;
  grant_t          last_grant;

  logic            full, empty, grant_r, grant_w, push, pop, store, consume;
  logic [31:0]     in_addr;
  entry_t          in_entry, head, out_entry;

  // Address bits outside the DDR3 map are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ar_addr[31:30], ar_addr[2:0], aw_addr[31:30], aw_addr[2:0]};

  function automatic logic [CW-1:0] next_ptr(input logic [CW-1:0] p);
    return (p == CW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Ties go to whichever channel did not win the last accepted transfer.
  always_comb begin
    grant_r = 1'b0;
    grant_w = 1'b0;
    if (!core_rst && !full) begin
      grant_r = ar_valid && (!aw_valid || last_grant == GRANT_WRITE);
      grant_w = aw_valid && (!ar_valid || last_grant == GRANT_READ);
    end
  end

  assign ar_ready = grant_r;
  assign aw_ready = grant_w;
  assign push     = grant_r || grant_w;

  always_comb begin
    in_addr        = grant_w ? aw_addr : ar_addr;
    in_entry       = '0;
    in_entry.write = grant_w;
    in_entry.bank  = in_addr[15:13];
    in_entry.row   = in_addr[29:16];
    in_entry.col   = in_addr[12:3];
    in_entry.id    = grant_w ? aw_id : ar_id;
    in_entry.len   = grant_w ? aw_len : ar_len;
  end

  assign head = mem[rd_ptr[PW-1:0]];

`ifdef NASTI_REQUEST_QUEUE_BYPASS_EN
  // An entry accepted into an empty queue is presented immediately and only
  // stored if the command generator does not take it in the same cycle.
  assign out_entry = (empty && push) ? in_entry : head;
  assign rq_valid  = !empty || push;
  assign consume   = empty && push && rq_ready;
`else
  assign out_entry = head;
  assign rq_valid  = !empty;
  assign consume   = 1'b0;
`endif

  assign pop     = rq_ready && !empty;
  assign store   = push && !consume;
  assign r_empty = empty;

  assign rq_write = out_entry.write;
  assign rq_bank  = out_entry.bank;
  assign rq_row   = out_entry.row;
  assign rq_col   = out_entry.col;
  assign rq_id    = out_entry.id;
  assign rq_len   = out_entry.len;

  always_ff @(posedge core_clk) begin
    if (store) mem[wr_ptr[PW-1:0]] <= in_entry;
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      last_grant <= GRANT_WRITE;
    end else begin
      if (store) wr_ptr <= next_ptr(wr_ptr);
      if (pop)   rd_ptr <= next_ptr(rd_ptr);
      if (store && !pop)      count <= count + 1'b1;
      else if (pop && !store) count <= count - 1'b1;
      if (push) last_grant <= grant_w ? GRANT_WRITE : GRANT_READ;
    end
  end

endmodule

// File: tb/tb_nasti_request_queue.sv
// Directed self-checking bench for nasti_request_queue (DEPTH=8, ID_W=4).
module tb_nasti_request_queue;

  logic        core_clk = 1'b0;
  logic        core_rst;
  logic        ar_valid, aw_valid, rq_ready;
  logic        ar_ready, aw_ready;
  logic [31:0] ar_addr, aw_addr;
  logic [3:0]  ar_id, aw_id, rq_id;
  logic [7:0]  ar_len, aw_len, rq_len;
  logic        rq_valid, rq_write, r_empty;
  logic [2:0]  rq_bank;
  logic [13:0] rq_row;
  logic [9:0]  rq_col;

  int checks   = 0;
  int failures = 0;

  nasti_request_queue #(.DEPTH(8), .ID_W(4)) dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id), .aw_len(aw_len),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_write(rq_write), .rq_bank(rq_bank),
    .rq_row(rq_row), .rq_col(rq_col), .rq_id(rq_id), .rq_len(rq_len), .r_empty(r_empty)
  );

  always #5 core_clk = ~core_clk;

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    core_rst = 1'b1;
    tick();
    core_rst = 1'b0;
  endtask

  initial begin
    core_rst = 1'b1;
    ar_valid = 0; aw_valid = 0; rq_ready = 0;
    ar_addr = '0; aw_addr = '0; ar_id = '0; aw_id = '0; ar_len = '0; aw_len = '0;
    tick();
    // Reset state, with a pending read that must not be accepted.
    ar_valid = 1;
    #1;
    chk("rst_ar_ready", ar_ready, 0);
    chk("rst_aw_ready", aw_ready, 0);
    chk("rst_rq_valid", rq_valid, 0);
    chk("rst_r_empty", r_empty, 1);
    tick();
    ar_valid = 0;
    chk("rst_no_push", rq_valid, 0);
    core_rst = 0;

    // Single read, address decode.
    ar_valid = 1; ar_addr = 32'h0001_A468; ar_id = 3; ar_len = 7;
    #1 chk("rd1_ar_ready", ar_ready, 1);
    tick();
    ar_valid = 0;
    chk("rd1_rq_valid", rq_valid, 1);
    chk("rd1_write", rq_write, 0);
    chk("rd1_bank", rq_bank, 5);
    chk("rd1_row", rq_row, 1);
    chk("rd1_col", rq_col, 10'h08D);
    chk("rd1_id", rq_id, 3);
    chk("rd1_len", rq_len, 7);
    chk("rd1_r_empty", r_empty, 0);
    rq_ready = 1;
    tick();
    chk("rd1_popped", r_empty, 1);
    // Pop request on an empty queue must not underflow.
    tick();
    rq_ready = 0;
    aw_valid = 1; aw_addr = 32'h0000_2008; aw_id = 6; aw_len = 1;
    tick();
    aw_valid = 0;
    chk("underflow_valid", rq_valid, 1);
    chk("wr_col", rq_col, 10'h001);
    chk("wr_bank", rq_bank, 1);
    chk("wr_write", rq_write, 1);

    // Arbitration: both channels valid, read wins first after reset.
    do_reset();
    ar_valid = 1; aw_valid = 1; ar_id = 1; aw_id = 2; ar_addr = '0; aw_addr = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("arb_ar_ready", ar_ready, (i % 2 == 0) ? 1 : 0);
      chk("arb_aw_ready", aw_ready, (i % 2 == 1) ? 1 : 0);
      tick();
    end
    ar_valid = 0; aw_valid = 0;
    rq_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("arb_order_valid", rq_valid, 1);
      chk("arb_order_write", rq_write, (i % 2 == 1) ? 1 : 0);
      chk("arb_order_id", rq_id, (i % 2 == 1) ? 2 : 1);
      tick();
    end
    rq_ready = 0;
    chk("arb_count4_drained", r_empty, 1);

    // Fill to DEPTH, then check backpressure including pop in the same cycle.
    do_reset();
    aw_valid = 1;
    for (int i = 0; i < 8; i++) begin
      aw_id = 4'(i); aw_len = 8'(i);
      #1 chk("fill_aw_ready", aw_ready, 1);
      tick();
    end
    aw_id = 8; aw_len = 8;
    #1 chk("full_aw_ready", aw_ready, 0);
    rq_ready = 1;
    #1 chk("full_pop_aw_ready", aw_ready, 0);
    tick();
    rq_ready = 0;
    chk("after_pop_aw_ready", aw_ready, 1);
    chk("after_pop_head", rq_id, 1);
    tick();
    aw_valid = 0;
    rq_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      chk("full_drain_id", rq_id, 32'(i));
      chk("full_drain_len", rq_len, 32'(i));
      tick();
    end
    rq_ready = 0;
    chk("full_drained", r_empty, 1);

    // Steady push+pop at count=3 across pointer wrap.
    do_reset();
    ar_valid = 1;
    for (int i = 0; i < 3; i++) begin
      ar_id = 4'(i);
      tick();
    end
    rq_ready = 1;
    for (int k = 0; k < 10; k++) begin
      ar_id = 4'(3 + k);
      #1 chk("pp_ar_ready", ar_ready, 1);
      chk("pp_head_id", rq_id, 32'(k));
      tick();
    end
    ar_valid = 0;
    for (int k = 10; k < 13; k++) begin
      chk("pp_tail_id", rq_id, 32'(k));
      chk("pp_tail_valid", rq_valid, 1);
      tick();
    end
    rq_ready = 0;
    chk("pp_count3_drained", r_empty, 1);

    // Reset with 5 stored entries discards them.
    ar_valid = 1;
    for (int i = 0; i < 5; i++) begin
      ar_id = 4'(i);
      tick();
    end
    ar_valid = 0;
    core_rst = 1;
    tick();
    core_rst = 0;
    chk("mid_rst_valid", rq_valid, 0);
    chk("mid_rst_empty", r_empty, 1);
    ar_valid = 1; ar_id = 9;
    tick();
    ar_valid = 0;
    chk("mid_rst_new_id", rq_id, 9);
    rq_ready = 1;
    tick();
    rq_ready = 0;
    chk("mid_rst_only_new", r_empty, 1);
    chk("mid_rst_no_ghost", rq_valid, 0);

`ifdef NASTI_REQUEST_QUEUE_BYPASS_EN
    ar_valid = 1; ar_id = 12; rq_ready = 1;
    #1;
    chk("byp_valid", rq_valid, 1);
    chk("byp_id", rq_id, 12);
    chk("byp_r_empty", r_empty, 1);
    tick();
    ar_valid = 0; rq_ready = 0;
    chk("byp_count0", r_empty, 1);
    chk("byp_not_stored", rq_valid, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
